// File: rtl/sat_slice_mc_if.sv
// Sample bus for the saturating bit-slicer: raw wide words in, sliced words,
// sticky overflow flags and saturation counters out.
interface sat_slice_mc_if #(
  parameter int N    = 2,
  parameter int WIN  = 64,
  parameter int WOUT = 32,
  parameter int SW   = 6,
  parameter int CNTW = 16
);
  logic              valid_i;
  logic [N*WIN-1:0]  sig_i;
  logic [SW-1:0]     shift_i;
  logic              round_i;
  logic              clr_i;
  logic              valid_o;
  logic [N*WOUT-1:0] sig_o;
  logic [N-1:0]      ovf_pos_o;
  logic [N-1:0]      ovf_neg_o;
  logic [N*CNTW-1:0] sat_cnt_o;

  modport master (
    output valid_i, sig_i, shift_i, round_i, clr_i,
    input  valid_o, sig_o, ovf_pos_o, ovf_neg_o, sat_cnt_o
  );

  modport slave (
    input  valid_i, sig_i, shift_i, round_i, clr_i,
    output valid_o, sig_o, ovf_pos_o, ovf_neg_o, sat_cnt_o
  );
endinterface

// File: rtl/sat_slice_mc.sv
// Multi-channel two-stage saturating slicer: stage 1 applies optional rounding,
// stage 2 shifts by the per-sample slice position and clips to the output range.
module sat_slice_mc #(
  parameter int N    = 2,
  parameter int WIN  = 64,
  parameter int WOUT = 32,
  parameter int SW   = 6,
  parameter int CNTW = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sat_slice_mc_if.slave bus
);
  localparam logic [SW-1:0] MAX_SHIFT = SW'(WIN - WOUT);

  logic [SW-1:0]     le;
  logic signed [WIN:0] rounded [N];

  logic              s1_valid;
  logic [SW-1:0]     s1_le;
  logic signed [WIN:0] s1_val [N];

  logic signed [WIN:0] shifted [N];
  logic [N-1:0]      in_range;
  logic [N-1:0]      pos_evt;
  logic [N-1:0]      neg_evt;
  logic [WOUT-1:0]   sliced [N];

  logic              valid_q;
  logic [N*WOUT-1:0] sig_q;
  logic [N-1:0]      pos_q;
  logic [N-1:0]      neg_q;
  logic [N*CNTW-1:0] cnt_q;

  // The extra sign bit lets the rounding constant be added without wrapping.
  always_comb begin
    le = (bus.shift_i > MAX_SHIFT) ? MAX_SHIFT : bus.shift_i;
    for (int k = 0; k < N; k++) begin
      rounded[k] = {bus.sig_i[k*WIN + WIN - 1], bus.sig_i[k*WIN +: WIN]};
      if (bus.round_i && (le != '0))
        rounded[k] = rounded[k] + ((WIN+1)'(1) << (le - SW'(1)));
    end
  end

  // In range exactly when every bit above the output sign bit matches it.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      shifted[k]  = s1_val[k] >>> s1_le;
      in_range[k] = (&shifted[k][WIN:WOUT-1]) || !(|shifted[k][WIN:WOUT-1]);
      pos_evt[k]  = s1_valid && !in_range[k] && !shifted[k][WIN];
      neg_evt[k]  = s1_valid && !in_range[k] &&  shifted[k][WIN];
      if (pos_evt[k])
        sliced[k] = {1'b0, {(WOUT-1){1'b1}}};
      else if (neg_evt[k])
        sliced[k] = {1'b1, {(WOUT-1){1'b0}}};
      else
        sliced[k] = shifted[k][WOUT-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_le    <= '0;
      for (int k = 0; k < N; k++) s1_val[k] <= '0;
      valid_q  <= 1'b0;
      sig_q    <= '0;
      pos_q    <= '0;
      neg_q    <= '0;
      cnt_q    <= '0;
    end else begin
      s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        s1_le <= le;
        for (int k = 0; k < N; k++) s1_val[k] <= rounded[k];
      end
      valid_q <= s1_valid;
      for (int k = 0; k < N; k++) begin
        if (s1_valid) sig_q[k*WOUT +: WOUT] <= sliced[k];

        if (pos_evt[k])      pos_q[k] <= 1'b1;
        else if (bus.clr_i)  pos_q[k] <= 1'b0;

        if (neg_evt[k])      neg_q[k] <= 1'b1;
        else if (bus.clr_i)  neg_q[k] <= 1'b0;

        // An event coinciding with a clear restarts the count at one.
        if (pos_evt[k] || neg_evt[k]) begin
          if (bus.clr_i)
            cnt_q[k*CNTW +: CNTW] <= CNTW'(1);
          else if (!(&cnt_q[k*CNTW +: CNTW]))
            cnt_q[k*CNTW +: CNTW] <= cnt_q[k*CNTW +: CNTW] + CNTW'(1);
        end else if (bus.clr_i) begin
          cnt_q[k*CNTW +: CNTW] <= '0;
        end
      end
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.sig_o     = sig_q;
  assign bus.ovf_pos_o = pos_q;
  assign bus.ovf_neg_o = neg_q;
  assign bus.sat_cnt_o = cnt_q;
endmodule

// File: doc/sat_slice_mc.md
# sat_slice_mc

Multi-channel, pipelined, saturating bit-slicer with a runtime-selectable slice position, optional round-half-up, and per-channel overflow monitoring. It reduces wide signed accumulator/filter words (e.g. lock-in demodulator outputs) to a narrower signed output word. The output clips to full scale instead of wrapping. Sits between the demodulation/filter chain and the output DAC/AXI register stage, replacing fixed-position single-channel slicing.

## Interface
- `N`, 2: number of independent channels.
- `WIN`, 64: signed input word width per channel.
- `WOUT`, 32: signed output word width per channel; `WOUT < WIN`.
- `SW`, 6: width of the slice-select input.
- `CNTW`, 16: width of each per-channel saturation event counter.

- `clk_i`  in  1: single clock; all logic on rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `valid_i`  in  1: input sample strobe; `sig_i`, `shift_i` and `round_i` are sampled only when it is high.
- `sig_i`  in  N*WIN: channel k occupies bits `[k*WIN +: WIN]`; two's complement.
- `shift_i`  in  SW: LSB position L of the slice; clamped to `WIN-WOUT`.
- `round_i`  in  1: 1 = round half up before slicing; 0 = truncate toward minus infinity.
- `clr_i`  in  1: clears sticky flags and counters.
- `valid_o`  out  1: output strobe, high 2 cycles after the accepted `valid_i`.
- `sig_o`  out  N*WOUT: sliced/saturated result; channel k at `[k*WOUT +: WOUT]`.
- `ovf_pos_o`  out  N: sticky positive-saturation flag per channel.
- `ovf_neg_o`  out  N: sticky negative-saturation flag per channel.
- `sat_cnt_o`  out  N*CNTW: per-channel saturation event counters.

## Operation
- **Effective shift:** `Le = min(shift_i, WIN-WOUT)`, captured with the sample. Each sample carries its own `Le` and `round_i` through the pipeline, so changing `shift_i` mid-stream affects only samples accepted after the change.
- **Stage 1 (register on valid_i):** sign-extend the input to WIN+1 bits.
  - If `round_i=1` and `Le>0`, add `2^(Le-1)`.
  - Because of the extra bit, the add itself never wraps.
  - Store the (WIN+1)-bit value and `Le`.
- **Stage 2:** arithmetic-shift the value right by `Le`. Compare the shifted value against the signed WOUT range.
  - Greater than `2^(WOUT-1)-1`: output `0111…1`; positive event.
  - Less than `-2^(WOUT-1)`: output `1000…0`; negative event.
  - Otherwise: output the low WOUT bits of the shifted value.
- **Sticky flags:** set on a qualified event (stage-2 valid only); cleared only by `clr_i` or `rst_i`.
  - If `clr_i` and an event occur in the same cycle, the event wins: the flag ends at 1 and the counter ends at 1.
- **Counter:** increments by 1 per saturated output sample, whether positive or negative.
  - Holds at all-ones; it does not wrap.
  - Cleared by `clr_i`.
- **Channel independence:** channels are fully independent except for the shared `valid`, `shift_i`, `round_i` and `clr_i`.
- **Reset:** `rst_i` mid-stream discards both pipeline stages, so no `valid_o` follows for in-flight samples.
  - All outputs read 0 the cycle after `rst_i` is sampled high: `sig_o`, `valid_o`, flags and counters.
  - `rst_i` has priority over `clr_i` and `valid_i`.

## Timing
- Latency: fixed 2 cycles from the `valid_i` edge to the `valid_o` edge. Throughput: 1 sample/cycle, back-to-back `valid_i` supported.
- `sig_o` holds its last value while `valid_o=0`. It is registered (no combinational input-to-output path).
- Flags and counters update on the same edge as the `sig_o` sample that caused them. They are therefore visible together with `valid_o`.
- No backpressure; the downstream stage must accept every `valid_o` pulse.

## Test plan
All scenarios use the default parameters, channel 0 unless stated.
- **Reset:** assert `rst_i` with `valid_i=1` and a full-scale input. Response: for 3 cycles `valid_o=0`, `sig_o=0`, flags=0, counters=0.
- **Truncate:** `shift_i=8`, `round_i=0`, `sig_i=0x0000_0000_1234_5680`. Response: `sig_o=0x00123456` at cycle +2, no flags.
- **Round:**
  - Same input with `round_i=1`: `0x00123457`.
  - `sig_i=-1`, `shift_i=4`: `round_i=0` gives `0xFFFFFFFF`; `round_i=1` gives `0x00000000`.
- **Saturation:**
  - `shift_i=0`, `sig_i=0x0000_0001_0000_0000`: `sig_o=0x7FFFFFFF`, `ovf_pos_o[0]=1`, counter=1.
  - `sig_i=0xFFFF_FFFE_0000_0000`: `sig_o=0x80000000`, `ovf_neg_o[0]=1`, counter=2.
  - `sig_i=0x0000_0007_FFFF_FFF8`, `shift_i=4`, `round_i=1`: saturates to `0x7FFFFFFF` (overflow caused by rounding).
- **Clamp and pipelining:**
  - `shift_i=63`: treated as 32, so `sig_i=0x1234_5678_0000_0000` gives `0x12345678`.
  - Alternate `shift_i` 0/8 on back-to-back samples: each output uses its own shift, with `valid_o` continuous.
- **Flag/counter boundaries:**
  - 65 536 consecutive saturating samples: counter holds at `0xFFFF`.
  - `clr_i` on the same cycle as an event: counter=1, flag=1.
  - `clr_i` alone: counter=0, flags=0.
  - Channel 1 unaffected throughout.
